// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 1024x768@60 timing, split-counter bases and elaboration-time split helpers.
package vga_timing_pkg;
  localparam int H_ACTIVE_DEF = 1024;
  localparam int H_FP_DEF = 24;
  localparam int H_SYNC_DEF = 136;
  localparam int H_BP_DEF = 160;
  localparam int V_ACTIVE_DEF = 768;
  localparam int V_FP_DEF = 3;
  localparam int V_SYNC_DEF = 6;
  localparam int V_BP_DEF = 29;
  localparam int X_BASE = 32;
  localparam int Y_BASE = 48;
  localparam int H_MAX = 2048;
  localparam int V_MAX = 1536;
  function automatic int split_hi(input int v, input int base);
    return v / base;
  endfunction
  function automatic int split_lo(input int v, input int base);
    return v % base;
  endfunction
  function automatic logic split_ge(input logic [7:0] hi, input logic [7:0] lo,
                                    input logic [7:0] c_hi, input logic [7:0] c_lo);
    return (hi > c_hi) || (hi == c_hi && lo >= c_lo);
  endfunction
endpackage

// File: rtl/split_counter.sv
// split_counter: mixed-radix {hi, lo} position counter wrapping at TOTAL, with next-state and wrap outputs.
module split_counter
  import vga_timing_pkg::*;
#(
  parameter int LO_MOD = 32,
  parameter int TOTAL = 1344,
  parameter int LO_W = 5,
  parameter int HI_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [LO_W-1:0] lo,
  output logic [HI_W-1:0] hi,
  output logic [LO_W-1:0] lo_d,
  output logic [HI_W-1:0] hi_d,
  output logic            wrap
);
  localparam logic [LO_W-1:0] LO_LAST = LO_W'(LO_MOD - 1);
  localparam logic [LO_W-1:0] END_LO = LO_W'(split_lo(TOTAL - 1, LO_MOD));
  localparam logic [HI_W-1:0] END_HI = HI_W'(split_hi(TOTAL - 1, LO_MOD));
  logic [LO_W-1:0] lo_q;
  logic [HI_W-1:0] hi_q;
  logic at_end, lo_last;
  assign at_end = (hi_q == END_HI) && (lo_q == END_LO);
  assign lo_last = (lo_q == LO_LAST);
  assign wrap = inc & at_end;
  assign lo = lo_q;
  assign hi = hi_q;
  always_comb begin
    lo_d = !inc ? lo_q : (at_end || lo_last) ? '0 : lo_q + 1'b1;
    hi_d = !inc ? hi_q : at_end ? '0 : lo_last ? hi_q + 1'b1 : hi_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end
endmodule

// File: rtl/vga_timing_split.sv
// vga_timing_split: free-running VGA timing with x/y as split base-32/base-48 counters.
module vga_timing_split
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [4:0] x_lo,
  output logic [5:0] x_hi,
  output logic [5:0] y_lo,
  output logic [4:0] y_hi,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > H_MAX || V_TOTAL > V_MAX) begin : g_bad_timing
    $fatal(1, "vga_timing_split: timing totals exceed split counter range");
  end
  localparam logic [7:0] HA_HI = 8'(split_hi(H_ACTIVE, X_BASE));
  localparam logic [7:0] HA_LO = 8'(split_lo(H_ACTIVE, X_BASE));
  localparam logic [7:0] HS_S_HI = 8'(split_hi(H_ACTIVE + H_FP, X_BASE));
  localparam logic [7:0] HS_S_LO = 8'(split_lo(H_ACTIVE + H_FP, X_BASE));
  localparam logic [7:0] HS_E_HI = 8'(split_hi(H_ACTIVE + H_FP + H_SYNC, X_BASE));
  localparam logic [7:0] HS_E_LO = 8'(split_lo(H_ACTIVE + H_FP + H_SYNC, X_BASE));
  localparam logic [7:0] VA_HI = 8'(split_hi(V_ACTIVE, Y_BASE));
  localparam logic [7:0] VA_LO = 8'(split_lo(V_ACTIVE, Y_BASE));
  localparam logic [7:0] VS_S_HI = 8'(split_hi(V_ACTIVE + V_FP, Y_BASE));
  localparam logic [7:0] VS_S_LO = 8'(split_lo(V_ACTIVE + V_FP, Y_BASE));
  localparam logic [7:0] VS_E_HI = 8'(split_hi(V_ACTIVE + V_FP + V_SYNC, Y_BASE));
  localparam logic [7:0] VS_E_LO = 8'(split_lo(V_ACTIVE + V_FP + V_SYNC, Y_BASE));
  logic [4:0] x_lo_d;
  logic [5:0] x_hi_d;
  logic [5:0] y_lo_d;
  logic [4:0] y_hi_d;
  logic x_wrap, y_wrap;
  logic hsync_q, vsync_q, blank_q, frame_start_q;
  logic hsync_d, vsync_d, blank_d;
  split_counter #(.LO_MOD(X_BASE), .TOTAL(H_TOTAL), .LO_W(5), .HI_W(6)) u_x (
    .clk(clk), .rst_n(rst_n), .inc(1'b1),
    .lo(x_lo), .hi(x_hi), .lo_d(x_lo_d), .hi_d(x_hi_d), .wrap(x_wrap)
  );
  split_counter #(.LO_MOD(Y_BASE), .TOTAL(V_TOTAL), .LO_W(6), .HI_W(5)) u_y (
    .clk(clk), .rst_n(rst_n), .inc(x_wrap),
    .lo(y_lo), .hi(y_hi), .lo_d(y_lo_d), .hi_d(y_hi_d), .wrap(y_wrap)
  );
  // decode the next position so registered flags line up with the registered counters
  always_comb begin
    hsync_d = (split_ge(8'(x_hi_d), 8'(x_lo_d), HS_S_HI, HS_S_LO) &&
               !split_ge(8'(x_hi_d), 8'(x_lo_d), HS_E_HI, HS_E_LO)) ? HSYNC_POL : !HSYNC_POL;
    vsync_d = (split_ge(8'(y_hi_d), 8'(y_lo_d), VS_S_HI, VS_S_LO) &&
               !split_ge(8'(y_hi_d), 8'(y_lo_d), VS_E_HI, VS_E_LO)) ? VSYNC_POL : !VSYNC_POL;
    blank_d = split_ge(8'(x_hi_d), 8'(x_lo_d), HA_HI, HA_LO) ||
              split_ge(8'(y_hi_d), 8'(y_lo_d), VA_HI, VA_LO);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= !HSYNC_POL;
      vsync_q <= !VSYNC_POL;
      blank_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      frame_start_q <= y_wrap;
    end
  end
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign blank = blank_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_split.sv
// tb_vga_timing_split: default-timing instance for line checks, shrunk-timing instance for whole frames.
module tb_vga_timing_split;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic d_hsync, d_vsync, d_blank, d_fs;
  logic [4:0] d_x_lo;
  logic [5:0] d_x_hi;
  logic [5:0] d_y_lo;
  logic [4:0] d_y_hi;
  logic s_hsync, s_vsync, s_blank, s_fs;
  logic [4:0] s_x_lo;
  logic [5:0] s_x_hi;
  logic [5:0] s_y_lo;
  logic [4:0] s_y_hi;
  localparam int S_FRAME = 54 * 59;
  int tests = 0;
  int fails = 0;
  int n, hs_cnt, hs_first, bl_cnt, bl_first, fs_cnt, fs_first, k;

  vga_timing_split u_dflt (
    .clk(clk), .rst_n(rst_n), .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank),
    .x_lo(d_x_lo), .x_hi(d_x_hi), .y_lo(d_y_lo), .y_hi(d_y_hi), .frame_start(d_fs)
  );
  vga_timing_split #(
    .H_ACTIVE(40), .H_FP(3), .H_SYNC(5), .H_BP(6),
    .V_ACTIVE(50), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank),
    .x_lo(s_x_lo), .x_hi(s_x_hi), .y_lo(s_y_lo), .y_hi(s_y_hi), .frame_start(s_fs)
  );

  typedef struct {int x_lo; int x_hi; int y_lo; int y_hi; int hs; int vs; int bl; int fs;} pix_t;

  // n = active edges since reset release; n = 0 is the reset state
  function automatic pix_t model(input int n, input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input int hp, input int vp);
    pix_t r;
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int p = n % (ht * vt);
    int x = p % ht;
    int y = p / ht;
    r.x_lo = x % 32;
    r.x_hi = x / 32;
    r.y_lo = y % 48;
    r.y_hi = y / 48;
    r.hs = (x >= ha + hf && x < ha + hf + hs) ? hp : 1 - hp;
    r.vs = (y >= va + vf && y < va + vf + vs) ? vp : 1 - vp;
    r.bl = (n > 0 && (x >= ha || y >= va)) ? 1 : 0;
    r.fs = (n > 0 && p == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s n=%0d got %0d want %0d", tag, n, got, want);
    end
  endtask

  task automatic chk_pix(input string tag, input pix_t a, input pix_t e);
    chk({tag, ".x_lo"}, a.x_lo, e.x_lo);
    chk({tag, ".x_hi"}, a.x_hi, e.x_hi);
    chk({tag, ".y_lo"}, a.y_lo, e.y_lo);
    chk({tag, ".y_hi"}, a.y_hi, e.y_hi);
    chk({tag, ".hsync"}, a.hs, e.hs);
    chk({tag, ".vsync"}, a.vs, e.vs);
    chk({tag, ".blank"}, a.bl, e.bl);
    chk({tag, ".frame_start"}, a.fs, e.fs);
  endtask

  task automatic check_both(input int m);
    pix_t a;
    a = '{int'(d_x_lo), int'(d_x_hi), int'(d_y_lo), int'(d_y_hi),
          int'(d_hsync), int'(d_vsync), int'(d_blank), int'(d_fs)};
    chk_pix("dflt", a, model(m, 1024, 24, 136, 160, 768, 3, 6, 29, 0, 0));
    a = '{int'(s_x_lo), int'(s_x_hi), int'(s_y_lo), int'(s_y_hi),
          int'(s_hsync), int'(s_vsync), int'(s_blank), int'(s_fs)};
    chk_pix("small", a, model(m, 40, 3, 5, 6, 50, 2, 3, 4, 1, 0));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
    check_both(n);
    if (s_fs) begin
      fs_cnt++;
      if (fs_first < 0) fs_first = n;
    end
  endtask

  initial begin
    n = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_both(0);
    chk("rst.hsync", int'(d_hsync), 1);
    chk("rst.vsync", int'(d_vsync), 1);
    rst_n = 1'b1;
    hs_cnt = 0; hs_first = -1; bl_cnt = 0; bl_first = -1; fs_cnt = 0; fs_first = -1;
    for (int i = 1; i <= 2 * S_FRAME + 5; i++) begin
      step();
      if (i == 1) chk("first_edge.x_lo", int'(d_x_lo), 1);
      if (i < 1344) begin
        if (!d_hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(d_x_hi) * 32 + int'(d_x_lo);
        end
        if (d_blank) begin
          bl_cnt++;
          if (bl_first < 0) bl_first = int'(d_x_hi) * 32 + int'(d_x_lo);
        end
      end
      if (i == 1343) begin
        chk("line_end.x_hi", int'(d_x_hi), 41);
        chk("line_end.x_lo", int'(d_x_lo), 31);
        chk("line_end.y_lo", int'(d_y_lo), 0);
      end
      if (i == 1344) begin
        chk("line_wrap.x", int'(d_x_hi) * 32 + int'(d_x_lo), 0);
        chk("line_wrap.y_lo", int'(d_y_lo), 1);
      end
    end
    chk("hsync_len", hs_cnt, 136);
    chk("hsync_start", hs_first, 1048);
    chk("blank_len", bl_cnt, 320);
    chk("blank_start", bl_first, 1024);
    chk("fs_count", fs_cnt, 2);
    chk("fs_first", fs_first, S_FRAME);
    k = int'($urandom_range(100, 3000));
    repeat (k) step();
    #2 rst_n = 1'b0;
    #1 check_both(0);
    repeat (int'($urandom_range(1, 3))) @(posedge clk);
    @(negedge clk);
    n = 0;
    check_both(0);
    rst_n = 1'b1;
    fs_cnt = 0; fs_first = -1;
    repeat (S_FRAME + 3) step();
    chk("fs_count_after_rst", fs_cnt, 1);
    chk("fs_first_after_rst", fs_first, S_FRAME);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
